// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM encodings and counter sizing.
`timescale 1ns/1ps
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter only needs to reach WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; ovf exists only with SERIAL_SUB_OVERFLOW_EN.
`timescale 1ns/1ps
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    , ovf
`endif
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    , ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from two half subtractors and an OR of their borrows.
`timescale 1ns/1ps
module half_subtractor (
  output logic d,
  output logic bout,
  input  logic a,
  input  logic b
);
  assign d    = a ^ b;
  assign bout = ~a & b;
endmodule

module full_subtractor (
  output logic d,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);
  logic d1, b1, b2;

  half_subtractor u_hs0 (.d(d1), .bout(b1), .a(a),  .b(b));
  half_subtractor u_hs1 (.d(d),  .bout(b2), .a(d1), .b(bin));

  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell and a registered borrow.
// Optional signed overflow flag when SERIAL_SUB_OVERFLOW_EN is defined.
`timescale 1ns/1ps
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | one bit per clock, busy=1
  // DONE  | single cycle, done=1, diff/borrow_out fresh; start accepted here too

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb, diff_q, res_nxt;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    count;
  logic             borrow, borrow_out_q;
  logic             d_bit, b_bit, last, load, busy_c, done_c;

  full_subtractor u_fsub (.d(d_bit), .bout(b_bit), .a(ra[0]), .b(rb[0]), .bin(borrow));

  // res holds the WIDTH-1 bits already produced; the current bit completes the result.
  assign res_nxt = {d_bit, res};
  assign last    = (count == CW'(WIDTH - 1));
  assign load    = bus.start && (state != SHIFT);

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = SHIFT;
      SHIFT: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = bus.start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ra           <= '0;
      rb           <= '0;
      res          <= '0;
      borrow       <= 1'b0;
      count        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        ra     <= bus.a;
        rb     <= bus.b;
        borrow <= 1'b0;
        count  <= '0;
      end else if (state == SHIFT) begin
        ra     <= ra >> 1;
        rb     <= rb >> 1;
        res    <= res_nxt[WIDTH-1:1];
        borrow <= b_bit;
        count  <= count + CW'(1);
        if (last) begin
          diff_q       <= res_nxt;
          borrow_out_q <= b_bit;
        end
      end
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic sign_a, sign_b, ovf_q;

  // Final diff MSB is the current bit on the last SHIFT edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      sign_a <= bus.a[WIDTH-1];
      sign_b <= bus.b[WIDTH-1];
    end else if (state == SHIFT && last) begin
      ovf_q <= (sign_a != sign_b) && (d_bit != sign_a);
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench: 8-bit vector table, back-to-back, reset mid-op, 4-bit exhaustive.
`timescale 1ns/1ps
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bo;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one 8-bit operation and wait for done; returns busy cycles seen and whether done arrived.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int nbusy, output bit got);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    tick();
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    nbusy = 0;
    got   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus8.done) begin
        got = 1'b1;
        break;
      end
      if (bus8.busy) nbusy++;
      tick();
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, output bit got);
    bus4.start = 1'b1;
    bus4.a     = a;
    bus4.b     = b;
    tick();
    bus4.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus4.done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Continuous invariants: done/busy exclusive, diff only moves on done or after reset.
  logic [7:0] prev_diff8 = '0;
  logic [3:0] prev_diff4 = '0;
  logic       prev_rst = 1'b1;
  always @(negedge clk) begin
    if (!prev_rst) begin
      chk("done_busy_excl8", {31'd0, bus8.done & bus8.busy}, 32'd0);
      chk("done_busy_excl4", {31'd0, bus4.done & bus4.busy}, 32'd0);
      if (!bus8.done) chk("diff_stable8", {24'd0, bus8.diff}, {24'd0, prev_diff8});
      if (!bus4.done) chk("diff_stable4", {28'd0, bus4.diff}, {28'd0, prev_diff4});
    end
    prev_diff8 = bus8.diff;
    prev_diff4 = bus4.diff;
    prev_rst   = rst;
  end

  initial begin
    vec_t vecs[9];
    int   nbusy;
    int   n;
    bit   got;
    logic [3:0] ed;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, diff: 8'h1E, bo: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, bo: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bo: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h10, b: 8'h20, diff: 8'hF0, bo: 1'b1, ovf: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, bo: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 8'h7F, b: 8'h80, diff: 8'hFF, bo: 1'b1, ovf: 1'b1};
    vecs[6] = '{a: 8'h00, b: 8'h00, diff: 8'h00, bo: 1'b0, ovf: 1'b0};
    vecs[7] = '{a: 8'h01, b: 8'hFF, diff: 8'h02, bo: 1'b1, ovf: 1'b0};
    vecs[8] = '{a: 8'hC3, b: 8'h5A, diff: 8'h69, bo: 1'b0, ovf: 1'b1};

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy",  {31'd0, bus8.busy}, 32'd0);
    chk("rst_done",  {31'd0, bus8.done}, 32'd0);
    chk("rst_diff",  {24'd0, bus8.diff}, 32'd0);
    chk("rst_bo",    {31'd0, bus8.borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_ovf",   {31'd0, bus8.ovf}, 32'd0);
`endif
    tick();

    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, nbusy, got);
      chk("vec_done",  {31'd0, got}, 32'd1);
      chk("vec_nbusy", nbusy, 32'd8);
      chk("vec_diff",  {24'd0, bus8.diff}, {24'd0, vecs[i].diff});
      chk("vec_bo",    {31'd0, bus8.borrow_out}, {31'd0, vecs[i].bo});
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk("vec_ovf",   {31'd0, bus8.ovf}, {31'd0, vecs[i].ovf});
`endif
      tick();
      chk("vec_done_pulse", {31'd0, bus8.done}, 32'd0);
      chk("vec_idle_busy",  {31'd0, bus8.busy}, 32'd0);
    end

    // Back-to-back with an ignored mid-SHIFT start and start held into DONE.
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h01;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20;
    tick();
    chk("b2b_busy_last", {31'd0, bus8.busy}, 32'd1);
    tick();
    chk("b2b_first_done", {31'd0, bus8.done}, 32'd1);
    chk("b2b_first_diff", {24'd0, bus8.diff}, 32'h1E);
    chk("b2b_first_bo",   {31'd0, bus8.borrow_out}, 32'd0);
    tick();
    bus8.start = 1'b0;
    bus8.a = 8'h77; bus8.b = 8'h11;
    chk("b2b_restart_busy", {31'd0, bus8.busy}, 32'd1);
    n = 1;
    while (!bus8.done && n < 30) begin
      tick();
      n++;
    end
    chk("b2b_spacing",     n, 32'd9);
    chk("b2b_second_diff", {24'd0, bus8.diff}, 32'hF0);
    chk("b2b_second_bo",   {31'd0, bus8.borrow_out}, 32'd1);
    tick();

    // Reset on the 4th SHIFT cycle discards the operation.
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, bus8.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus8.done}, 32'd0);
    chk("midrst_diff", {24'd0, bus8.diff}, 32'd0);
    chk("midrst_bo",   {31'd0, bus8.borrow_out}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done || bus8.busy) got = 1'b1;
      tick();
    end
    chk("midrst_quiet", {31'd0, got}, 32'd0);
    run8(8'h00, 8'h01, nbusy, got);
    chk("midrst_fresh_done", {31'd0, got}, 32'd1);
    chk("midrst_fresh_diff", {24'd0, bus8.diff}, 32'hFF);
    chk("midrst_fresh_bo",   {31'd0, bus8.borrow_out}, 32'd1);
    tick();

    // WIDTH=4 exhaustive against a simple arithmetic scoreboard.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run4(4'(ia), 4'(ib), got);
        ed = 4'(ia - ib);
        chk("w4_done", {31'd0, got}, 32'd1);
        chk("w4_diff", {28'd0, bus4.diff}, {28'd0, ed});
        chk("w4_bo",   {31'd0, bus4.borrow_out}, (ia < ib) ? 32'd1 : 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("w4_ovf",  {31'd0, bus4.ovf},
            {31'd0, (ia[3] != ib[3]) && (ed[3] != ia[3])});
`endif
      end
    end
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
